// File: rtl/ripple_carry_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ripple_carry_adder_pkg
//  Description : Shared constants for the ripple-carry adder block.
//  Revision    : 1.0 - initial release
// ============================================================================
package ripple_carry_adder_pkg;

    // Default operand/sum width used when the parent does not override WIDTH.
    localparam int ADDER_WIDTH = 4;

endpackage : ripple_carry_adder_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder
//  Description : One-bit combinational full adder; one stage of the ripple
//                chain in ripple_carry_adder.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder
    import ripple_carry_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum is the parity of the three inputs; carry is their majority.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule : full_adder
`default_nettype wire

// File: rtl/ripple_carry_adder.sv
`default_nettype none
// ============================================================================
//  Module      : ripple_carry_adder
//  Description : Parameterised unsigned adder built from a chain of WIDTH
//                full adders. The carry ripples from bit 0 upward; sum and
//                carry-out are registered for one cycle of latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module ripple_carry_adder
    import ripple_carry_adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);

    // carry[i] is the carry into bit i; carry[WIDTH] is the adder carry-out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    assign carry[0] = cin;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            full_adder u_fa (
                .a    (a[i]),
                .b    (b[i]),
                .cin  (carry[i]),
                .s    (sum_comb[i]),
                .cout (carry[i+1])
            );
        end
    endgenerate

    // Output register: reset wins; results load only on qualified cycles so
    // unqualified (possibly undriven) operands never reach sum/cout.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= sum_comb;
                cout <= carry[WIDTH];
            end
        end
    end

endmodule : ripple_carry_adder
`default_nettype wire

// File: tb/tb_ripple_carry_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ripple_carry_adder
//  Description : Directed self-checking bench for ripple_carry_adder at
//                WIDTH=4, WIDTH=1 and WIDTH=16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ripple_carry_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // WIDTH=4 instance
    logic [3:0]  a4 = '0, b4 = '0, sum4;
    logic        cin4 = 1'b0, vld4 = 1'b0, cout4, ov4;
    // WIDTH=1 instance
    logic [0:0]  a1 = '0, b1 = '0, sum1;
    logic        cin1 = 1'b0, vld1 = 1'b0, cout1, ov1;
    // WIDTH=16 instance
    logic [15:0] a16 = '0, b16 = '0, sum16;
    logic        cin16 = 1'b0, vld16 = 1'b0, cout16, ov16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ripple_carry_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4), .in_valid(vld4),
        .sum(sum4), .cout(cout4), .out_valid(ov4)
    );

    ripple_carry_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .in_valid(vld1),
        .sum(sum1), .cout(cout1), .out_valid(ov1)
    );

    ripple_carry_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16), .in_valid(vld16),
        .sum(sum16), .cout(cout16), .out_valid(ov16)
    );

    // Advance one rising edge; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic [3:0] ta, input logic [3:0] tb,
                          input logic tc, input logic tv);
        a4 = ta; b4 = tb; cin4 = tc; vld4 = tv;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom); vld4 = 1'b1;
            tick();
            checks++;
            if ({sum4, cout4, ov4} !== 6'b0000_0_0) begin
                errors++;
                $display("FAIL reset_%0d: sum=%b cout=%b out_valid=%b required 0000 0 0",
                         i, sum4, cout4, ov4);
            end
        end
        rst = 1'b0;
        drive4(4'b0000, 4'b0000, 1'b0, 1'b1);
        checks++;
        if ({sum4, cout4, ov4} !== 6'b0000_0_1) begin
            errors++;
            $display("FAIL reset_release: sum=%b cout=%b out_valid=%b required 0000 0 1",
                     sum4, cout4, ov4);
        end
    endtask

    task automatic test_basic();
        logic [3:0] va [4] = '{4'b0001, 4'b0110, 4'b1001, 4'b0111};
        logic [3:0] vb [4] = '{4'b0001, 4'b0011, 4'b0110, 4'b0001};
        logic [3:0] vs [4] = '{4'b0010, 4'b1001, 4'b1111, 4'b1000};
        for (int i = 0; i < 4; i++) begin
            drive4(va[i], vb[i], 1'b0, 1'b1);
            checks++;
            if ({sum4, cout4, ov4} !== {vs[i], 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL basic_%0d: sum=%b cout=%b ov=%b required %b 0 1",
                         i, sum4, cout4, ov4, vs[i]);
            end
        end
    endtask

    task automatic test_carry_in();
        logic [3:0] va [4] = '{4'b0000, 4'b0110, 4'b1001, 4'b1010};
        logic [3:0] vb [4] = '{4'b0000, 4'b0011, 4'b0110, 4'b0101};
        logic [3:0] vs [4] = '{4'b0001, 4'b1010, 4'b0000, 4'b0000};
        logic       vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive4(va[i], vb[i], 1'b1, 1'b1);
            checks++;
            if ({sum4, cout4, ov4} !== {vs[i], vc[i], 1'b1}) begin
                errors++;
                $display("FAIL carry_in_%0d: sum=%b cout=%b ov=%b required %b %b 1",
                         i, sum4, cout4, ov4, vs[i], vc[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [3:0] va [3] = '{4'b1111, 4'b1111, 4'b1111};
        logic [3:0] vb [3] = '{4'b0001, 4'b1111, 4'b0000};
        logic       vi [3] = '{1'b0, 1'b1, 1'b1};
        logic [3:0] vs [3] = '{4'b0000, 4'b1111, 4'b0000};
        for (int i = 0; i < 3; i++) begin
            drive4(va[i], vb[i], vi[i], 1'b1);
            checks++;
            if ({sum4, cout4, ov4} !== {vs[i], 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL overflow_%0d: sum=%b cout=%b ov=%b required %b 1 1",
                         i, sum4, cout4, ov4, vs[i]);
            end
        end
    endtask

    task automatic test_valid_hold();
        drive4(4'b0011, 4'b0100, 1'b0, 1'b1);
        checks++;
        if ({sum4, cout4, ov4} !== 6'b0111_0_1) begin
            errors++;
            $display("FAIL hold_first: sum=%b cout=%b ov=%b required 0111 0 1", sum4, cout4, ov4);
        end
        // Unqualified operands that would otherwise carry out must be ignored.
        drive4(4'b1111, 4'b1111, 1'b1, 1'b0);
        checks++;
        if ({sum4, cout4, ov4} !== 6'b0111_0_0) begin
            errors++;
            $display("FAIL hold_gap: sum=%b cout=%b ov=%b required 0111 0 0", sum4, cout4, ov4);
        end
        drive4(4'b0010, 4'b0010, 1'b1, 1'b1);
        checks++;
        if ({sum4, cout4, ov4} !== 6'b0101_0_1) begin
            errors++;
            $display("FAIL hold_resume: sum=%b cout=%b ov=%b required 0101 0 1", sum4, cout4, ov4);
        end
    endtask

    task automatic test_reset_mid_stream();
        drive4(4'b1111, 4'b0001, 1'b0, 1'b1);
        checks++;
        if ({sum4, cout4, ov4} !== 6'b0000_1_1) begin
            errors++;
            $display("FAIL mid_pre: sum=%b cout=%b ov=%b required 0000 1 1", sum4, cout4, ov4);
        end
        rst = 1'b1;
        drive4(4'b0101, 4'b0001, 1'b0, 1'b1);
        rst = 1'b0;
        checks++;
        if ({sum4, cout4, ov4} !== 6'b0000_0_0) begin
            errors++;
            $display("FAIL mid_reset: sum=%b cout=%b ov=%b required 0000 0 0", sum4, cout4, ov4);
        end
    endtask

    task automatic test_exhaustive4();
        logic [4:0] exp;
        for (int i = 0; i < 512; i++) begin
            exp = 5'(i[3:0]) + 5'(i[7:4]) + 5'(i[8]);
            drive4(i[3:0], i[7:4], i[8], 1'b1);
            checks++;
            if ({cout4, sum4} !== exp || ov4 !== 1'b1) begin
                errors++;
                $display("FAIL exh4 a=%b b=%b cin=%b: got cout,sum=%b ov=%b required %b 1",
                         i[3:0], i[7:4], i[8], {cout4, sum4}, ov4, exp);
            end
        end
        vld4 = 1'b0;
    endtask

    task automatic test_width1();
        logic [1:0] exp;
        for (int i = 0; i < 8; i++) begin
            a1 = i[0]; b1 = i[1]; cin1 = i[2]; vld1 = 1'b1;
            exp = 2'(i[0]) + 2'(i[1]) + 2'(i[2]);
            tick();
            checks++;
            if ({cout1, sum1} !== exp || ov1 !== 1'b1) begin
                errors++;
                $display("FAIL w1 a=%b b=%b cin=%b: got %b ov=%b required %b 1",
                         i[0], i[1], i[2], {cout1, sum1}, ov1, exp);
            end
        end
        vld1 = 1'b0;
    endtask

    task automatic test_width16();
        logic [16:0] exp;
        for (int i = 0; i < 41; i++) begin
            if (i == 0) begin
                a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1;
            end else if (i == 1) begin
                a16 = 16'hFFFF; b16 = 16'h0000; cin16 = 1'b1;
            end else begin
                a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
            end
            vld16 = 1'b1;
            exp = 17'(a16) + 17'(b16) + 17'(cin16);
            tick();
            checks++;
            if ({cout16, sum16} !== exp || ov16 !== 1'b1) begin
                errors++;
                $display("FAIL w16 a=%h b=%h cin=%b: got %h ov=%b required %h 1",
                         a16, b16, cin16, {cout16, sum16}, ov16, exp);
            end
        end
        vld16 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_in();
        test_overflow();
        test_valid_hold();
        test_reset_mid_stream();
        test_exhaustive4();
        test_width1();
        test_width16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ripple_carry_adder
`default_nettype wire
